adc_avg_monitor: RTL and testbench

- Sits directly downstream of the 7-channel SPI ADC controller and consumes its adc_data[7] 12-bit result array.
- Periodically snapshots each channel and box-car averages 2^AVG_LOG2 snapshots per channel.
- Publishes the averaged array with a one-cycle valid strobe, plus a per-channel over-threshold alarm, for the data-gathering/logging logic.

---
 rtl/adc_avg_monitor.sv | 140 ++++++++++++++
 tb/tb_adc_avg_monitor.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_avg_monitor.sv
// adc_avg_monitor: periodic snapshot and box-car average of NCH ADC channels.
// Define ADC_AVG_ALARM_LATCH_EN to make alarm_hi sticky until alarm_clr.
module adc_avg_monitor #(
  parameter int NCH        = 7,
  parameter int WIDTH      = 12,
  parameter int AVG_LOG2   = 3,
  parameter int SAMPLE_DIV = 128
) (
  input  logic             c1m,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] adc_data [NCH],
  input  logic [WIDTH-1:0] thresh_hi,
  input  logic             alarm_clr,
  output logic [WIDTH-1:0] avg_data [NCH],
  output logic             avg_valid,
  output logic [NCH-1:0]   alarm_hi,
  output logic             busy
);

  localparam int AW = WIDTH + AVG_LOG2;
  localparam logic [15:0] DIV_END = 16'(SAMPLE_DIV - NCH - 2);
  localparam logic [2:0]  IDX_END = 3'(NCH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_SCAN,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [AW-1:0]       acc [NCH];
  logic [AVG_LOG2-1:0] cnt;
  logic [15:0]         div;
  logic [2:0]          idx;
  logic                publish;
  logic [NCH-1:0]      above;

  assign publish = (state == S_DONE) && (&cnt);

  // State register
  always_ff @(posedge c1m or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state: WAIT paces the period, SCAN walks the channels
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (enable) state_nxt = S_WAIT;
      S_WAIT: begin
        if (!enable)             state_nxt = S_IDLE;
        else if (div == DIV_END) state_nxt = S_SCAN;
      end
      S_SCAN: if (idx == IDX_END) state_nxt = S_DONE;
      S_DONE: state_nxt = enable ? S_WAIT : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy = (state == S_SCAN) || (state == S_DONE);
  end

  // Per-channel averages compared against the threshold
  always_comb begin
    above = '0;
    for (int n = 0; n < NCH; n++)
      above[n] = acc[n][AW-1:AVG_LOG2] > thresh_hi;
  end

  // Divider, channel index, window count and accumulators
  always_ff @(posedge c1m or posedge rst) begin
    if (rst) begin
      div <= '0;
      cnt <= '0;
      idx <= '0;
      for (int n = 0; n < NCH; n++) acc[n] <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          div <= '0;
          cnt <= '0;
          idx <= '0;
          for (int n = 0; n < NCH; n++) acc[n] <= '0;
        end
        S_WAIT: begin
          div <= div + 16'd1;
          idx <= '0;
        end
        S_SCAN: begin
          idx <= idx + 3'd1;
          for (int n = 0; n < NCH; n++)
            if (idx == 3'(n))
              acc[n] <= acc[n] + AW'(adc_data[n]);
        end
        S_DONE: begin
          div <= '0;
          if (&cnt) begin
            cnt <= '0;
            for (int n = 0; n < NCH; n++) acc[n] <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: div <= '0;
      endcase
    end
  end

  // Publish averages, valid strobe and alarms
  always_ff @(posedge c1m or posedge rst) begin
    if (rst) begin
      avg_valid <= 1'b0;
      alarm_hi  <= '0;
      for (int n = 0; n < NCH; n++) avg_data[n] <= '0;
    end else begin
      avg_valid <= publish;
      if (publish)
        for (int n = 0; n < NCH; n++)
          avg_data[n] <= acc[n][AW-1:AVG_LOG2];
`ifdef ADC_AVG_ALARM_LATCH_EN
      alarm_hi <= (alarm_hi & ~{NCH{alarm_clr}})
                | (above & {NCH{publish}});
`else
      if (publish) alarm_hi <= above;
`endif
    end
  end

`ifndef ADC_AVG_ALARM_LATCH_EN
  logic clr_unused;
  assign clr_unused = alarm_clr;
`endif

endmodule

// File: tb/tb_adc_avg_monitor.sv
// tb_adc_avg_monitor: directed stimulus with a timing-level reference model.
// Model tracks cycles since enable; snapshots and publishes at fixed offsets.
module tb_adc_avg_monitor;

  localparam int NCH = 7;
  localparam int W   = 12;

  logic         c1m = 1'b0;
  logic         rst = 1'b1;
  logic         enable = 1'b0;
  logic         alarm_clr = 1'b0;
  logic [W-1:0] adc [NCH];
  logic [W-1:0] thresh_hi;
  logic [W-1:0] avg_data [NCH];
  logic         avg_valid;
  logic         busy;
  logic [NCH-1:0] alarm_hi;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  bit             m_act = 0;
  int             m_t = 0;
  int             m_acc [NCH];
  logic [W-1:0]   m_avg [NCH];
  logic [NCH-1:0] m_alarm = '0;
  bit             m_valid = 0;
  bit             m_busy = 0;

  adc_avg_monitor dut (
    .c1m       (c1m),
    .rst       (rst),
    .enable    (enable),
    .adc_data  (adc),
    .thresh_hi (thresh_hi),
    .alarm_clr (alarm_clr),
    .avg_data  (avg_data),
    .avg_valid (avg_valid),
    .alarm_hi  (alarm_hi),
    .busy      (busy)
  );

  always #5 c1m = ~c1m;

  always @(posedge c1m) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] pack(input logic [W-1:0] a [NCH]);
    logic [127:0] r;
    r = '0;
    for (int n = 0; n < NCH; n++) r[n*W +: W] = a[n];
    return r;
  endfunction

  // Reference model: enable seen at t=0; channel c snapshot j read at
  // edge 121+128*j+c; window published at every multiple of 1024.
  always @(posedge c1m) begin
    m_valid = 0;
    if (rst) begin
      m_act = 0;
      m_t = 0;
      m_alarm = '0;
      for (int n = 0; n < NCH; n++) begin
        m_acc[n] = 0;
        m_avg[n] = '0;
      end
    end else begin
`ifdef ADC_AVG_ALARM_LATCH_EN
      if (alarm_clr) m_alarm = '0;
`endif
      if (!m_act) begin
        if (enable) begin
          m_act = 1;
          m_t = 0;
          for (int n = 0; n < NCH; n++) m_acc[n] = 0;
        end
      end else if (!enable) begin
        m_act = 0;
        for (int n = 0; n < NCH; n++) m_acc[n] = 0;
      end else begin
        m_t++;
        if (m_t >= 121 && (m_t - 121) % 128 < NCH)
          m_acc[(m_t - 121) % 128] += int'(adc[(m_t - 121) % 128]);
        if (m_t % 1024 == 0) begin
          for (int n = 0; n < NCH; n++) begin
            m_avg[n] = 12'(m_acc[n] / 8);
`ifdef ADC_AVG_ALARM_LATCH_EN
            if (m_avg[n] > thresh_hi) m_alarm[n] = 1'b1;
`else
            m_alarm[n] = m_avg[n] > thresh_hi;
`endif
            m_acc[n] = 0;
          end
          m_valid = 1;
        end
      end
    end
    m_busy = m_act && m_t >= 120 && (m_t - 120) % 128 < NCH + 1;
  end

  always @(posedge c1m) begin
    #2;
    check("avg_valid", avg_valid, m_valid);
    check("busy", busy, m_busy);
    check("alarm_hi", alarm_hi, m_alarm);
    check("avg_data", pack(avg_data), pack(m_avg));
  end

  task automatic set_all(input logic [W-1:0] v);
    for (int n = 0; n < NCH; n++) adc[n] = v;
  endtask

  task automatic next_snap();
    int k;
    k = 0;
    do begin
      @(negedge c1m);
      k++;
    end while (!(m_act && m_t % 128 == 64) && k < 400);
    check("next_snap timeout", k < 400, 1);
  endtask

  task automatic wait_pub(output int at);
    int k;
    k = 0;
    do begin
      @(negedge c1m);
      k++;
    end while (!avg_valid && k < 1200);
    check("wait_pub timeout", k < 1200, 1);
    at = cyc;
  endtask

  initial begin
    int c0, p1, p2, p, k;
    thresh_hi = 12'hFFF;
    set_all(12'h000);
    repeat (2) @(negedge c1m);
    check("rst avg_valid", avg_valid, 0);
    check("rst busy", busy, 0);
    check("rst alarm", alarm_hi, 0);
    check("rst avg_data", pack(avg_data), 0);
    rst = 1'b0;
    @(negedge c1m);

    enable = 1'b1;
    c0 = cyc;
    for (int j = 0; j < 8; j++) begin
      next_snap();
      set_all(12'h800);
    end
    wait_pub(p1);
    check("A latency", p1 - c0, 1025);
    for (int n = 0; n < NCH; n++) check("A avg", avg_data[n], 12'h800);
    @(negedge c1m);
    check("A pulse width", avg_valid, 0);

    for (int j = 0; j < 8; j++) begin
      next_snap();
      set_all(12'h800);
      adc[0] = (j % 2 == 1) ? 12'hFFF : 12'h000;
    end
    wait_pub(p2);
    check("B period", p2 - p1, 1024);
    check("B avg ch0", avg_data[0], 12'h7FF);
    check("B avg ch1", avg_data[1], 12'h800);

    for (int j = 0; j < 8; j++) begin
      next_snap();
      thresh_hi = 12'h400;
      set_all(12'h000);
      adc[3] = 12'h401;
      adc[4] = 12'h400;
    end
    wait_pub(p);
    check("C alarm", alarm_hi, 7'b0001000);
    check("C avg ch3", avg_data[3], 12'h401);
    check("C avg ch4", avg_data[4], 12'h400);

    for (int j = 0; j < 8; j++) begin
      next_snap();
      adc[3] = 12'h000;
    end
    wait_pub(p);
    check("D avg ch3", avg_data[3], 12'h000);
`ifdef ADC_AVG_ALARM_LATCH_EN
    check("D alarm sticky", alarm_hi, 7'b0001000);
    alarm_clr = 1'b1;
    @(negedge c1m);
    alarm_clr = 1'b0;
    check("D alarm cleared", alarm_hi, 7'b0000000);

    for (int j = 0; j < 8; j++) begin
      next_snap();
      set_all(12'h000);
      adc[5] = 12'hFFF;
    end
    k = 0;
    do begin
      @(negedge c1m);
      k++;
    end while (m_t % 1024 != 1023 && k < 400);
    check("E align timeout", k < 400, 1);
    alarm_clr = 1'b1;
    @(negedge c1m);
    alarm_clr = 1'b0;
    check("E set wins", alarm_hi, 7'b0100000);
    check("E valid", avg_valid, 1);
`else
    check("D alarm level", alarm_hi, 7'b0000000);
`endif

    for (int j = 0; j < 4; j++) begin
      next_snap();
      set_all(12'h100);
    end
    next_snap();
    enable = 1'b0;
    repeat (30) @(negedge c1m);
    check("F idle busy", busy, 0);
`ifdef ADC_AVG_ALARM_LATCH_EN
    check("F kept ch4", avg_data[4], 12'h000);
    check("F kept ch5", avg_data[5], 12'hFFF);
`else
    check("F kept ch4", avg_data[4], 12'h400);
    check("F kept ch5", avg_data[5], 12'h000);
`endif
    enable = 1'b1;
    c0 = cyc;
    for (int j = 0; j < 8; j++) begin
      next_snap();
      set_all(12'h200);
    end
    wait_pub(p);
    check("F latency", p - c0, 1025);
    for (int n = 0; n < NCH; n++) check("F avg", avg_data[n], 12'h200);

    k = 0;
    do begin
      @(negedge c1m);
      k++;
    end while (!(m_act && m_t >= 120 && m_t % 128 == 122) && k < 400);
    check("G align timeout", k < 400, 1);
    check("G busy in scan", busy, 1);
    rst = 1'b1;
    #1;
    check("G rst avg_valid", avg_valid, 0);
    check("G rst busy", busy, 0);
    check("G rst alarm", alarm_hi, 0);
    check("G rst avg_data", pack(avg_data), 0);
    @(negedge c1m);
    rst = 1'b0;
    repeat (200) @(negedge c1m);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
